intr_sync_gateway: RTL and testbench
====================================

# intr_sync_gateway

Interrupt gateway consuming the 1-bit output of a 3-stage async-reset synchronizer on each external interrupt line. Debounces the synchronized level, converts it to a single pending request (level- or edge-triggered), and holds it through a valid/ready claim plus complete handshake toward the interrupt controller. One instance per interrupt source; sits directly downstream of the synchronizer and upstream of the controller's priority logic.

## Interface
- STABLE_CYCLES, 2: consecutive equal samples required before io_filtered follows io_sync_d; legal range 1..255.
- CNT_W, 8: width of the dropped-edge counter.

- clock  in  1  sole clock; io_sync_d is already synchronous to it.
- reset  in  1  synchronous, active-high; sampled on clock rising edge.
- io_sync_d  in  1  synchronized interrupt level from the synchronizer.
- io_level_mode  in  1  1 = level-triggered, 0 = edge-triggered (rising edge); quasi-static.
- io_filtered  out  1  debounced level.
- io_plic_valid  out  1  request pending, not yet claimed.
- io_plic_ready  in  1  controller claims the request.
- io_plic_complete  in  1  controller finished servicing.
- io_drop_count  out  CNT_W  saturating count of edges lost (see Configuration).

## Operation
- Filter: counter increments while io_sync_d != io_filtered; clears when equal. When io_sync_d != io_filtered has been sampled on STABLE_CYCLES consecutive edges, io_filtered flips on the last of those edges and the counter clears. Shorter pulses are ignored. STABLE_CYCLES=1 gives a plain register.
- rise = io_filtered flipping 0->1 on this edge (registered event, one cycle).
- FSM states IDLE, PEND, INFLIGHT:
  - IDLE: level mode and io_filtered=1 -> PEND; edge mode and rise -> PEND.
  - PEND: io_plic_valid=1. io_plic_ready=1 -> INFLIGHT. io_plic_complete ignored.
  - INFLIGHT: io_plic_complete=1 -> PEND if (level mode and io_filtered=1) or missed=1, else IDLE. io_plic_ready ignored.
- missed flag (edge mode only): set by rise while state is PEND or INFLIGHT; cleared on the INFLIGHT->PEND transition it causes; forced 0 while io_level_mode=1. Rise while missed=1 is dropped.
- Simultaneous complete and rise in INFLIGHT (edge mode): transition to PEND; missed stays 0.
- io_plic_ready while IDLE has no effect.

## Timing
- Reset values: io_filtered=0, io_plic_valid=0, io_drop_count=0, state IDLE, filter counter 0, missed 0.
- io_sync_d rises and holds: io_filtered=1 after STABLE_CYCLES edges; io_plic_valid=1 one edge later (total STABLE_CYCLES+1).
- io_plic_valid deasserts on the edge where valid&ready is sampled.
- INFLIGHT->PEND re-arm: io_plic_valid reasserts the edge after complete is sampled.
- Reset mid-operation: all state returns to reset values on the next edge; a pending request is discarded; a held-high input re-enters via the filter (STABLE_CYCLES+1 cycles after reset release).

## Configuration
- INTR_GW_DROP_COUNT_EN defined: io_drop_count increments by 1 on each dropped rise (rise while missed=1), saturating at 2^CNT_W-1; cleared only by reset.
- Not defined: counter logic omitted; io_drop_count tied to 0. All other behaviour identical.

## Test plan
- Reset, STABLE_CYCLES=2, edge mode: io_sync_d 1-cycle pulse -> io_filtered and io_plic_valid stay 0.
- io_sync_d 0->1 at edge 10, held -> io_filtered=1 after edge 11, io_plic_valid=1 after edge 12; ready at edge 14 -> valid=0 after edge 14; complete at edge 16 -> IDLE, no re-request.
- Level mode, line held high, claim then complete -> io_plic_valid reasserts the edge after complete; drop line before complete -> returns to IDLE.
- Edge mode, three separate rises during INFLIGHT -> one re-request after complete; io_drop_count=2 with INTR_GW_DROP_COUNT_EN, 0 without.
- Assert reset during PEND with line high -> io_plic_valid=0 after reset edge; reasserts STABLE_CYCLES+1 edges after reset release.
- CNT_W=2, macro on: 5 dropped rises -> io_drop_count saturates at 3.

Source files
------------

// File: rtl/intr_sync_gateway.sv
// Per-line interrupt gateway: debounce filter, level/edge request FSM, claim/complete handshake.
// Optional `INTR_GW_DROP_COUNT_EN adds a saturating counter of rises lost while a re-request is already owed.
//
// state       | meaning
// ST_IDLE     | no request outstanding
// ST_PEND     | request offered to the controller (io_plic_valid=1)
// ST_INFLIGHT | claimed, waiting for complete
module intr_sync_gateway #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_sync_d,
    input  logic             io_level_mode,
    output logic             io_filtered,
    output logic             io_plic_valid,
    input  logic             io_plic_ready,
    input  logic             io_plic_complete,
    output logic [CNT_W-1:0] io_drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND     = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [7:0] flt_cnt_q, flt_cnt_d;
    logic       filt_q, filt_d;
    logic       rise_q, rise_d;
    state_t     state_q;
    logic       valid_q;
    logic       missed_q;
    logic       level_req;
    logic       edge_rise;
    logic       busy;

    // The flip happens on the STABLE_CYCLES-th consecutive differing sample.
    always_comb begin
        flt_cnt_d = '0;
        filt_d    = filt_q;
        rise_d    = 1'b0;
        if (io_sync_d != filt_q) begin
            if (flt_cnt_q == STABLE_LAST) begin
                filt_d = io_sync_d;
                rise_d = io_sync_d;
            end else begin
                flt_cnt_d = flt_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flt_cnt_q <= '0;
            filt_q    <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            filt_q    <= filt_d;
            rise_q    <= rise_d;
        end
    end

    assign level_req = io_level_mode & filt_q;
    assign edge_rise = ~io_level_mode & rise_q;
    assign busy      = (state_q == ST_PEND) || (state_q == ST_INFLIGHT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (level_req || edge_rise) begin
                        state_q <= ST_PEND;
                        valid_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (io_plic_ready) begin
                        state_q <= ST_INFLIGHT;
                        valid_q <= 1'b0;
                    end
                end
                ST_INFLIGHT: begin
                    // A rise coinciding with complete re-arms directly instead of via missed.
                    if (io_plic_complete) begin
                        if (level_req || missed_q || edge_rise) begin
                            state_q <= ST_PEND;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase

            if (io_level_mode) begin
                missed_q <= 1'b0;
            end else if ((state_q == ST_INFLIGHT) && io_plic_complete) begin
                missed_q <= 1'b0;
            end else if (edge_rise && busy) begin
                missed_q <= 1'b1;
            end
        end
    end

    assign io_filtered   = filt_q;
    assign io_plic_valid = valid_q;

`ifdef INTR_GW_DROP_COUNT_EN
    logic [CNT_W-1:0] drop_cnt_q;
    logic             drop_evt;

    assign drop_evt = edge_rise & missed_q & busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_evt && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign io_drop_count = drop_cnt_q;
`else
    assign io_drop_count = '0;
`endif

endmodule

// File: tb/tb_intr_sync_gateway.sv
// Directed bench for intr_sync_gateway: per-cycle expected outputs queued at drive time, popped after the edge.
module tb_intr_sync_gateway;

    localparam int CNT_W = 2;
`ifdef INTR_GW_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             sync_d;
    logic             level_mode;
    logic             filtered;
    logic             plic_valid;
    logic             plic_ready;
    logic             plic_complete;
    logic [CNT_W-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        logic  filt;
        logic  valid;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    intr_sync_gateway #(
        .STABLE_CYCLES(2),
        .CNT_W        (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_sync_d       (sync_d),
        .io_level_mode   (level_mode),
        .io_filtered     (filtered),
        .io_plic_valid   (plic_valid),
        .io_plic_ready   (plic_ready),
        .io_plic_complete(plic_complete),
        .io_drop_count   (drop_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic s, input logic rdy,
                       input logic cmp, input logic ef, input logic ev);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        sync_d        = s;
        plic_ready    = rdy;
        plic_complete = cmp;
        e.tag   = tag;
        e.filt  = ef;
        e.valid = ev;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".filt"}, 32'(filtered), 32'(e.filt));
            check_val({e.tag, ".valid"}, 32'(plic_valid), 32'(e.valid));
        end
    endtask

    function automatic logic [31:0] exp_drop(input int n);
        int v;
        v = (n > 3) ? 3 : n;
        return DROP_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin
        reset         = 1'b1;
        sync_d        = 1'b0;
        level_mode    = 1'b0;
        plic_ready    = 1'b0;
        plic_complete = 1'b0;

        cyc("rst", 1, 0, 0, 0, 0, 0);
        cyc("rst", 1, 0, 0, 0, 0, 0);
        check_val("rst.drop", 32'(drop_count), 32'd0);

        // short pulse is filtered out
        cyc("pulse", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("pulse", 0, 0, 0, 0, 0, 0);

        // edge mode: request, claim, complete, no re-request
        cyc("edge", 0, 1, 0, 0, 0, 0);
        cyc("edge", 0, 1, 0, 0, 1, 0);
        cyc("edge", 0, 1, 0, 0, 1, 1);
        cyc("edge", 0, 1, 0, 0, 1, 1);
        cyc("edge", 0, 1, 1, 0, 1, 0);
        cyc("edge", 0, 1, 0, 0, 1, 0);
        cyc("edge", 0, 1, 0, 1, 1, 0);
        cyc("edge", 0, 1, 0, 0, 1, 0);
        cyc("edge", 0, 1, 0, 0, 1, 0);
        cyc("edge", 0, 0, 0, 0, 1, 0);
        cyc("edge", 0, 0, 0, 0, 0, 0);
        cyc("idle_rdy", 0, 0, 1, 0, 0, 0);

        // level mode: re-arm while high, back to idle once dropped
        level_mode = 1'b1;
        cyc("lvl", 0, 1, 0, 0, 0, 0);
        cyc("lvl", 0, 1, 0, 0, 1, 0);
        cyc("lvl", 0, 1, 0, 0, 1, 1);
        cyc("lvl", 0, 1, 1, 0, 1, 0);
        cyc("lvl", 0, 1, 0, 0, 1, 0);
        cyc("lvl_rearm", 0, 1, 0, 1, 1, 1);
        cyc("lvl", 0, 1, 1, 0, 1, 0);
        cyc("lvl", 0, 0, 0, 0, 1, 0);
        cyc("lvl", 0, 0, 0, 0, 0, 0);
        cyc("lvl_done", 0, 0, 0, 1, 0, 0);
        cyc("lvl", 0, 0, 0, 0, 0, 0);

        // edge mode: three rises during INFLIGHT
        level_mode = 1'b0;
        cyc("miss", 0, 1, 0, 0, 0, 0);
        cyc("miss", 0, 1, 0, 0, 1, 0);
        cyc("miss", 0, 1, 0, 0, 1, 1);
        cyc("miss", 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("miss_tog", 0, 0, 0, 0, 1, 0);
            cyc("miss_tog", 0, 0, 0, 0, 0, 0);
            cyc("miss_tog", 0, 1, 0, 0, 0, 0);
            cyc("miss_tog", 0, 1, 0, 0, 1, 0);
        end
        cyc("miss", 0, 1, 0, 0, 1, 0);
        check_val("miss.drop", 32'(drop_count), exp_drop(2));
        cyc("miss_rearm", 0, 1, 0, 1, 1, 1);
        cyc("miss", 0, 1, 1, 0, 1, 0);
        cyc("miss_done", 0, 1, 0, 1, 1, 0);
        cyc("miss", 0, 1, 0, 0, 1, 0);

        // reset while PEND with line high
        cyc("rstp", 0, 0, 0, 0, 1, 0);
        cyc("rstp", 0, 0, 0, 0, 0, 0);
        cyc("rstp", 0, 1, 0, 0, 0, 0);
        cyc("rstp", 0, 1, 0, 0, 1, 0);
        cyc("rstp", 0, 1, 0, 0, 1, 1);
        cyc("rstp_rst", 1, 1, 0, 0, 0, 0);
        check_val("rstp.drop", 32'(drop_count), 32'd0);
        cyc("rstp_rel", 0, 1, 0, 0, 0, 0);
        cyc("rstp_rel", 0, 1, 0, 0, 1, 0);
        cyc("rstp_rel", 0, 1, 0, 0, 1, 1);

        // saturation: first rise sets missed, next five are dropped
        for (int i = 1; i <= 6; i++) begin
            cyc("sat", 0, 0, 0, 0, 1, 1);
            check_val("sat.drop", 32'(drop_count), exp_drop((i < 2) ? 0 : i - 2));
            cyc("sat", 0, 0, 0, 0, 0, 1);
            cyc("sat", 0, 1, 0, 0, 0, 1);
            cyc("sat", 0, 1, 0, 0, 1, 1);
        end
        cyc("sat", 0, 1, 0, 0, 1, 1);
        check_val("sat.final", 32'(drop_count), exp_drop(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
